// File: rtl/resta_serial_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor.
package resta_serial_pkg;

    // Default operand/result width.
    localparam int DEF_WIDTH = 8;

    // Control FSM state encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : resta_serial_pkg

// File: rtl/resta_serial_restador_completo.sv
// One-bit full subtractor (d = a ^ b ^ bi, bo = borrow out), built from
// named gate primitives so power analysis can tag each cell.

module xor2_p (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule : xor2_p

module and2_p (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule : and2_p

module or3_p (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a | b | c;
endmodule : or3_p

module restador_completo #(
    parameter int PwrC = 0
) (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic ab_x_s;
    logic na_s;
    logic na_b_s;
    logic na_bi_s;
    logic b_bi_s;

    // The power tag only labels the instance; it never changes the logic.
    if (PwrC != 0) begin : g_pwr_tagged
    end

    // Difference bit.
    xor2_p u_x0 (.a(a),      .b(b),    .y(ab_x_s));
    xor2_p u_x1 (.a(ab_x_s), .b(bi),   .y(d));

    // Inverting a with an XOR keeps the cell set to xor/and/or only.
    xor2_p u_inv (.a(a), .b(1'b1), .y(na_s));

    // Borrow: ~a&b | ~a&bi | b&bi.
    and2_p u_a0 (.a(na_s), .b(b),  .y(na_b_s));
    and2_p u_a1 (.a(na_s), .b(bi), .y(na_bi_s));
    and2_p u_a2 (.a(b),    .b(bi), .y(b_bi_s));
    or3_p  u_o0 (.a(na_b_s), .b(na_bi_s), .c(b_bi_s), .y(bo));

endmodule : restador_completo

// File: rtl/resta_serial.sv
// Bit-serial subtractor: d = a - b - bi computed LSB first, one bit per
// clock through a single full-subtractor cell, with valid/ready on both sides.
module resta_serial
    import resta_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PwrC  = 0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] d,
    output logic             bo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic             release_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             brw_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] d_r;
    logic             bo_r;
    logic             valid_r;
    logic             ready_r;

    logic             dbit_s;
    logic             bout_s;

    // Shared full-subtractor cell working on the bit selected by the counter.
    restador_completo #(
        .PwrC (PwrC)
    ) u_fs (
        .a  (a_r[cnt_r]),
        .b  (b_r[cnt_r]),
        .bi (brw_r),
        .d  (dbit_s),
        .bo (bout_s)
    );

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        step_s    = 1'b0;
        last_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (valid_in) begin
                    accept_s = 1'b1;
                    state_s  = S_RUN;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    last_s  = 1'b1;
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                if (ready_in) begin
                    release_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    state_s   = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, serial bit processing and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            brw_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            bo_r    <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            brw_r   <= bi;
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b0;
        end else if (step_s) begin
            d_r[cnt_r] <= dbit_s;
            brw_r      <= bout_s;
            if (last_s) begin
                // Counter parks on the last bit so it never wraps inside RUN.
                bo_r    <= bout_s;
                valid_r <= 1'b1;
            end else begin
                cnt_r   <= cnt_r + CW'(1);
            end
        end else if (release_s) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end
    end

    assign ready_out = ready_r;
    assign valid_out = valid_r;
    assign d         = d_r;
    assign bo        = bo_r;

endmodule : resta_serial

// File: tb/tb_resta_serial.sv
// Self-checking bench for resta_serial: directed corner cases, an
// in-flight reset, and randomized operands with random output stalls.
module tb_resta_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_L;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] d;
    logic         bo;

    int n_vec = 0;
    int n_err = 0;

    resta_serial #(
        .WIDTH (W),
        .PwrC  (0)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .d         (d),
        .bo        (bo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: unsigned a - b - bi; borrow when the true result is negative.
    function automatic logic [W:0] ref_sub(input int ua, input int ub, input int ubi);
        int r;
        logic bo_e;
        r    = ua - ub - ubi;
        bo_e = (r < 0);
        if (r < 0) r = r + (1 << W);
        return {bo_e, r[W-1:0]};
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                         input int stall);
        logic [W:0] exp;
        exp = ref_sub(int'(ta), int'(tb), int'(tbi));
        @(negedge clk);
        check_val("idle_rdy", ready_out, 1'b1);
        valid_in = 1'b1;
        a        = ta;
        b        = tb;
        bi       = tbi;
        ready_in = 1'($urandom);
        @(posedge clk);
        #1;
        // Scramble inputs: they must only be sampled at the accept edge.
        valid_in = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        bi       = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check_val("run_vld", valid_out, 1'b0);
            check_val("run_rdy", ready_out, 1'b0);
            ready_in = 1'($urandom);
            valid_in = 1'($urandom);
        end
        @(negedge clk);
        check_val("done_vld", valid_out, 1'b1);
        check_val("result", {bo, d}, exp);
        check_val("done_rdy", ready_out, 1'b0);
        for (int s = 0; s < stall; s++) begin
            ready_in = 1'b0;
            valid_in = 1'($urandom);
            @(negedge clk);
            check_val("stall_vld", valid_out, 1'b1);
            check_val("stall_res", {bo, d}, exp);
            check_val("stall_rdy", ready_out, 1'b0);
        end
        ready_in = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check_val("rel_vld", valid_out, 1'b0);
        check_val("rel_rdy", ready_out, 1'b1);
        check_val("rel_hold", {bo, d}, exp);
        ready_in = 1'b0;
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a        = '0;
        b        = '0;
        bi       = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_rdy", ready_out, 1'b1);
        check_val("rst_vld", valid_out, 1'b0);
        check_val("rst_d", d, 8'h00);
        check_val("rst_bo", bo, 1'b0);
        reset_L = 1'b1;

        // Directed corner cases.
        do_op(8'h05, 8'h03, 1'b0, 0);
        check_val("t1_d", d, 8'h02);
        do_op(8'h00, 8'h01, 1'b0, 1);
        check_val("t2a", {bo, d}, 9'h1FF);
        do_op(8'h80, 8'h7F, 1'b1, 2);
        check_val("t2b", {bo, d}, 9'h000);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        check_val("t3", {bo, d}, 9'h1FF);
        do_op(8'h3C, 8'hA5, 1'b0, 20);

        // Reset while the op is processing bit 4.
        @(negedge clk);
        valid_in = 1'b1;
        a        = 8'h55;
        b        = 8'h22;
        bi       = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        reset_L = 1'b0;
        #1;
        check_val("mid_rst_vld", valid_out, 1'b0);
        check_val("mid_rst_rdy", ready_out, 1'b1);
        check_val("mid_rst_d", d, 8'h00);
        check_val("mid_rst_bo", bo, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            check_val("no_ghost", valid_out, 1'b0);
        end
        do_op(8'h10, 8'h01, 1'b0, 1);
        check_val("t5_d", d, 8'h0F);

        // Randomized operands with random consumer stalls.
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_resta_serial
